mac_sequencer: RTL and testbench

//  Operand-side driver for the 16x16->32 multiply-accumulate block (accumulator).

---
 rtl/mac_sequencer_if.sv | 38 +++
 rtl/mac_sequencer.sv | 134 +++++++++++++
 tb/tb_mac_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_sequencer_if.sv
// Stream bundle for mac_sequencer: sample and weight AXI-Stream inputs plus the
// result AXI-Stream output. "slave" is the sequencer's view, "master" the environment's.
interface mac_sequencer_if #(
    parameter int DW = 16,
    parameter int AW = 32
);
    logic [DW-1:0] s_i_TDATA;
    logic          s_i_TVALID;
    logic          s_i_TLAST;
    logic          s_i_TREADY;

    logic [DW-1:0] s_k_TDATA;
    logic          s_k_TVALID;
    logic          s_k_TREADY;

    logic [AW-1:0] m_TDATA;
    logic          m_TVALID;
    logic          m_TLAST;
    logic          m_TREADY;

    modport slave (
        input  s_i_TDATA, s_i_TVALID, s_i_TLAST,
        output s_i_TREADY,
        input  s_k_TDATA, s_k_TVALID,
        output s_k_TREADY,
        output m_TDATA, m_TVALID, m_TLAST,
        input  m_TREADY
    );

    modport master (
        output s_i_TDATA, s_i_TVALID, s_i_TLAST,
        input  s_i_TREADY,
        output s_k_TDATA, s_k_TVALID,
        input  s_k_TREADY,
        input  m_TDATA, m_TVALID, m_TLAST,
        output m_TREADY
    );
endinterface

// File: rtl/mac_sequencer.sv
// Operand-side driver for the external 16x16->32 multiply-accumulate block: joins
// sample/weight streams, issues TAPS products per word and returns the dot product.
module mac_sequencer #(
    parameter int TAPS = 9,
    parameter int DW   = 16,
    parameter int AW   = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic [DW-1:0] bias,
    mac_sequencer_if.slave axis,
    output logic [DW-1:0] i_TDATA,
    output logic [DW-1:0] k_TDATA,
    output logic [DW-1:0] b_TDATA,
    output logic          r1_enable,
    output logic          enable,
    output logic          m_enable,
    input  logic [AW-1:0] o_TDATA,
    output logic          busy,
    output logic          err_tlast
);

    localparam int            CW       = $clog2(TAPS + 1);
    localparam logic [CW-1:0] LAST_TAP = CW'(TAPS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] tap_cnt;
    logic [1:0]    drain_cnt;
    logic          r1_first;
    logic          last_tlast;

    logic accept;
    logic first_tap;
    logic final_tap;

    // A pair moves only on the joint handshake; a lone valid is left in place.
    assign accept    = (state == RUN) && axis.s_i_TVALID && axis.s_k_TVALID;
    assign first_tap = (tap_cnt == '0);
    assign final_tap = (tap_cnt == LAST_TAP);

    assign axis.s_i_TREADY = (state == RUN);
    assign axis.s_k_TREADY = (state == RUN);
    assign busy            = (state != IDLE);

    // Operand registers and the two-stage control pipeline feeding the accumulator.
    // NOTE: state elements use non-blocking assignments so every register samples
    // pre-edge values; blocking here would let r1_enable ripple into enable in one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_TDATA    <= '0;
            k_TDATA    <= '0;
            b_TDATA    <= '0;
            r1_enable  <= 1'b0;
            r1_first   <= 1'b0;
            enable     <= 1'b0;
            m_enable   <= 1'b0;
            last_tlast <= 1'b0;
            err_tlast  <= 1'b0;
        end else begin
            r1_enable <= accept;
            r1_first  <= accept && first_tap;
            enable    <= r1_enable;
            m_enable  <= r1_first;
            if (accept) begin
                i_TDATA    <= axis.s_i_TDATA;
                k_TDATA    <= axis.s_k_TDATA;
                last_tlast <= axis.s_i_TLAST;
                if (first_tap) begin
                    b_TDATA <= bias;
                end
                if (axis.s_i_TLAST && !final_tap) begin
                    err_tlast <= 1'b1;
                end
            end
        end
    end

    // Group sequencing. DRAIN waits out the product and sum stages of the final tap
    // (two edges), then captures the settled sum on the third.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            tap_cnt       <= '0;
            drain_cnt     <= '0;
            axis.m_TDATA  <= '0;
            axis.m_TVALID <= 1'b0;
            axis.m_TLAST  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (final_tap) begin
                            tap_cnt   <= '0;
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end else begin
                            tap_cnt <= tap_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'd2) begin
                        axis.m_TDATA  <= o_TDATA;
                        axis.m_TVALID <= 1'b1;
                        axis.m_TLAST  <= last_tlast;
                        state         <= OUT;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                OUT: begin
                    // run is only consulted here, so a group in flight always finishes.
                    if (axis.m_TREADY) begin
                        axis.m_TVALID <= 1'b0;
                        state         <= run ? RUN : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: accumulator model on the operand side, phase/arithmetic
// reference model, per-cycle comparison, directed cases and randomized groups.
module tb_mac_sequencer;

    localparam int TAPS = 3;
    localparam int DW   = 16;
    localparam int AW   = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic [DW-1:0] bias;
    logic [DW-1:0] i_TDATA, k_TDATA, b_TDATA;
    logic          r1_enable, enable, m_enable;
    logic [AW-1:0] o_TDATA;
    logic          busy, err_tlast;

    mac_sequencer_if #(.DW(DW), .AW(AW)) axis ();

    mac_sequencer #(.TAPS(TAPS), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .bias      (bias),
        .axis      (axis),
        .i_TDATA   (i_TDATA),
        .k_TDATA   (k_TDATA),
        .b_TDATA   (b_TDATA),
        .r1_enable (r1_enable),
        .enable    (enable),
        .m_enable  (m_enable),
        .o_TDATA   (o_TDATA),
        .busy      (busy),
        .err_tlast (err_tlast)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Accumulator: product register loads on r1_enable, sum on enable, seeded by bias.
    logic [31:0] acc_prod, acc_sum;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_prod <= '0;
            acc_sum  <= '0;
        end else begin
            if (r1_enable) acc_prod <= 32'(i_TDATA) * 32'(k_TDATA);
            if (enable)    acc_sum  <= (m_enable ? 32'(b_TDATA) : acc_sum) + acc_prod;
        end
    end
    assign o_TDATA = acc_sum;

    // Reference model: what the outputs must be, from the behavioural rules.
    typedef enum {P_IDLE, P_COLLECT, P_WAIT, P_PRESENT} phase_t;
    phase_t      ph = P_IDLE;
    int          cyc = 0;
    bit          acc_at   [1024];
    bit          first_at [1024];
    int          n = 0;
    int          wait_until = 0;
    logic [31:0] gsum = '0, e_data = '0;
    logic [15:0] e_i = '0, e_k = '0, e_b = '0;
    bit          e_err = 0, e_valid = 0, e_last = 0, g_last = 0;

    task automatic model_step();
        bit a;
        cyc++;
        if (!reset) begin
            ph = P_IDLE; n = 0; gsum = '0; e_i = '0; e_k = '0; e_b = '0;
            e_err = 0; e_valid = 0; e_last = 0; g_last = 0;
            acc_at[cyc % 1024] = 0; first_at[cyc % 1024] = 0;
        end else begin
            a = (ph == P_COLLECT) && axis.s_i_TVALID && axis.s_k_TVALID;
            acc_at[cyc % 1024]   = a;
            first_at[cyc % 1024] = a && (n == 0);
            case (ph)
                P_IDLE: if (run) ph = P_COLLECT;
                P_COLLECT: if (a) begin
                    if (n == 0) begin
                        gsum = 32'(bias);
                        e_b  = bias;
                    end
                    gsum   = gsum + 32'(axis.s_i_TDATA) * 32'(axis.s_k_TDATA);
                    e_i    = axis.s_i_TDATA;
                    e_k    = axis.s_k_TDATA;
                    g_last = axis.s_i_TLAST;
                    if (axis.s_i_TLAST && n != TAPS - 1) e_err = 1;
                    n++;
                    if (n == TAPS) begin
                        n = 0;
                        ph = P_WAIT;
                        wait_until = cyc + 3;
                    end
                end
                P_WAIT: if (cyc == wait_until) begin
                    ph = P_PRESENT; e_valid = 1; e_data = gsum; e_last = g_last;
                end
                P_PRESENT: if (axis.m_TREADY) begin
                    e_valid = 0;
                    ph = run ? P_COLLECT : P_IDLE;
                end
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison on the falling edge.
    int men_total = 0;
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            check("rst_outputs", {i_TDATA, k_TDATA}, 32'd0);
            check("rst_bias", 32'(b_TDATA), 32'd0);
            check("rst_ctrl", {29'd0, r1_enable, enable, m_enable}, 32'd0);
            check("rst_m_data", axis.m_TDATA, 32'd0);
            check("rst_flags", {27'd0, axis.m_TVALID, axis.m_TLAST, axis.s_i_TREADY,
                                busy, err_tlast}, 32'd0);
        end else if (cyc >= 1) begin
            if (m_enable) men_total++;
            check("r1_enable", 32'(r1_enable), 32'(acc_at[cyc % 1024]));
            check("enable",    32'(enable),    32'(acc_at[(cyc - 1) % 1024]));
            check("m_enable",  32'(m_enable),  32'(first_at[(cyc - 1) % 1024]));
            check("s_i_TREADY", 32'(axis.s_i_TREADY), 32'(ph == P_COLLECT));
            check("s_k_TREADY", 32'(axis.s_k_TREADY), 32'(ph == P_COLLECT));
            check("busy",      32'(busy),      32'(ph != P_IDLE));
            check("err_tlast", 32'(err_tlast), 32'(e_err));
            check("i_TDATA",   32'(i_TDATA),   32'(e_i));
            check("k_TDATA",   32'(k_TDATA),   32'(e_k));
            check("b_TDATA",   32'(b_TDATA),   32'(e_b));
            check("m_TVALID",  32'(axis.m_TVALID), 32'(e_valid));
            if (e_valid) begin
                check("m_TDATA", axis.m_TDATA, e_data);
                check("m_TLAST", 32'(axis.m_TLAST), 32'(e_last));
            end
        end
    end

    // Stimulus helpers; inputs change 1 time unit after the rising edge.
    logic [15:0] ga [TAPS];
    logic [15:0] gb [TAPS];
    bit rnd_mode = 0;

    task automatic idle_in();
        axis.s_i_TVALID = 1'b0;
        axis.s_k_TVALID = 1'b0;
        axis.s_i_TLAST  = 1'b0;
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b,
                             input bit last, input int lag);
        bit hs = 0;
        axis.s_i_TDATA  = a;
        axis.s_i_TLAST  = last;
        axis.s_i_TVALID = 1'b1;
        if (lag > 0) begin
            axis.s_k_TVALID = 1'b0;
            repeat (lag) begin
                @(posedge clk);
                #1;
            end
        end
        axis.s_k_TDATA  = b;
        axis.s_k_TVALID = 1'b1;
        for (int t = 0; t < 200 && !hs; t++) begin
            @(negedge clk);
            hs = axis.s_i_TREADY && reset;
            @(posedge clk);
            #1;
        end
        if (!hs) check("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_group(input logic [15:0] bv, input int lastpos, input int lag);
        bias = bv;
        for (int t = 0; t < TAPS; t++) send_pair(ga[t], gb[t], t == lastpos, lag);
        idle_in();
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        for (int t = 1; t <= 40 && lat == 0; t++) begin
            @(posedge clk);
            #1;
            if (axis.m_TVALID) lat = t;
        end
        if (lat == 0) check("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic take_result();
        axis.m_TREADY = 1'b1;
        @(posedge clk);
        #1;
        axis.m_TREADY = 1'b0;
    endtask

    task automatic fill(input logic [15:0] a0, a1, a2, b0, b1, b2);
        ga[0] = a0; ga[1] = a1; ga[2] = a2;
        gb[0] = b0; gb[1] = b1; gb[2] = b2;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_mode) axis.m_TREADY = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int men0;
        reset = 1'b1;
        run   = 1'b0;
        bias  = '0;
        axis.s_i_TDATA = '0;
        axis.s_k_TDATA = '0;
        axis.m_TREADY  = 1'b0;
        idle_in();
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ready", 32'(axis.s_i_TREADY), 32'd0);
        run = 1'b1;

        // 1: back-to-back pairs, latency and single bias-select cycle.
        fill(1, 3, 5, 2, 4, 6);
        men0 = men_total;
        send_group(16'd10, -1, 0);
        wait_result(lat);
        check("t1_latency", 32'(lat), 32'd3);
        check("t1_data", axis.m_TDATA, 32'd54);
        check("t1_model", e_data, 32'd54);
        check("t1_m_enable_cycles", 32'(men_total - men0), 32'd1);
        take_result();

        // 2: weight stream lagging by two cycles per beat.
        send_group(16'd10, -1, 2);
        wait_result(lat);
        check("t2_data", axis.m_TDATA, 32'd54);

        // 3: result back-pressured with a pair already waiting.
        axis.s_i_TDATA = 16'd1; axis.s_k_TDATA = 16'd1;
        axis.s_i_TVALID = 1'b1; axis.s_k_TVALID = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(posedge clk);
            #1;
            check("t3_hold_data", axis.m_TDATA, 32'd54);
            check("t3_hold_ready", 32'(axis.s_i_TREADY), 32'd0);
        end
        take_result();
        fill(1, 1, 1, 1, 1, 1);
        send_group(16'd0, -1, 0);
        wait_result(lat);
        check("t3_data", axis.m_TDATA, 32'd3);
        take_result();

        // 4: modulo 2^32 wrap.
        fill(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        send_group(16'hFFFF, -1, 0);
        wait_result(lat);
        check("t4_data", axis.m_TDATA, 32'hFFFB0002);
        check("t4_model", e_data, 32'hFFFB0002);
        take_result();

        // 5: early TLAST flags an error; proper TLAST closes the frame; run=0 at exit.
        fill(1, 2, 3, 4, 5, 6);
        send_group(16'd0, 1, 0);
        wait_result(lat);
        check("t5_err", 32'(err_tlast), 32'd1);
        check("t5_tlast_early", 32'(axis.m_TLAST), 32'd0);
        check("t5_data_early", axis.m_TDATA, 32'd32);
        take_result();
        send_group(16'd0, 2, 0);
        run = 1'b0;
        wait_result(lat);
        check("t5_tlast", 32'(axis.m_TLAST), 32'd1);
        check("t5_err_sticky", 32'(err_tlast), 32'd1);
        take_result();
        check("t5_idle_after_run_low", 32'(busy), 32'd0);
        run = 1'b1;

        // 6: asynchronous reset in DRAIN, then a clean group.
        fill(7, 7, 7, 9, 9, 9);
        send_group(16'd1, -1, 0);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_enable", {30'd0, r1_enable, enable}, 32'd0);
        check("t6_err", 32'(err_tlast), 32'd0);
        check("t6_i", 32'(i_TDATA), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        fill(2, 2, 2, 3, 3, 3);
        send_group(16'd5, -1, 0);
        wait_result(lat);
        check("t6_data", axis.m_TDATA, 32'd23);
        take_result();

        // Randomized groups with back-pressure, lags, gaps and run toggling.
        rnd_mode = 1;
        for (int g = 0; g < 40; g++) begin
            for (int t = 0; t < TAPS; t++) begin
                ga[t] = 16'($urandom);
                gb[t] = 16'($urandom);
            end
            run = 1'b1;
            send_group(16'($urandom),
                       ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TAPS - 1)) : -1,
                       int'($urandom_range(0, 2)));
            if ($urandom_range(0, 3) == 0) run = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_mode = 0;
        run = 1'b1;
        @(posedge clk);
        #2 axis.m_TREADY = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("end_drained", 32'(axis.m_TVALID), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
